// File: rtl/multi_counter.sv
// Multi-channel accumulating counter with wrap/saturate, sticky overflow and threshold flags.
// One-cycle update latency; no backpressure, so every enabled edge accumulates.
module multi_counter #(
    parameter int                 WIDTH_P = 8,
    parameter int                 NUM_CH  = 4,
    parameter logic [WIDTH_P-1:0] THR_RST = '0
) (
    input  logic                        clk1,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           en,
    input  logic [NUM_CH-1:0]           clr,
    input  logic [NUM_CH*WIDTH_P-1:0]   inc,
    input  logic                        sat_mode,
    input  logic                        thr_we,
    input  logic [WIDTH_P-1:0]          thr_wdata,
    input  logic [NUM_CH-1:0]           ovf_ack,
    output logic [NUM_CH*WIDTH_P-1:0]   val,
    output logic [NUM_CH-1:0]           overflow,
    output logic [NUM_CH-1:0]           thr_hit,
    output logic [NUM_CH-1:0]           non_zero,
    output logic                        any_ovf
);

    logic [WIDTH_P-1:0] thr_q;
    logic [WIDTH_P-1:0] val_q [NUM_CH];
    logic [WIDTH_P-1:0] val_d [NUM_CH];
    logic [WIDTH_P:0]   sum   [NUM_CH];
    logic [NUM_CH-1:0]  ovf_d;
    logic [NUM_CH-1:0]  hit_d;

    always_comb begin
        ovf_d = overflow & ~ovf_ack;
        hit_d = thr_hit;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]   = {1'b0, val_q[i]} + {1'b0, inc[i*WIDTH_P +: WIDTH_P]};
            val_d[i] = val_q[i];
            if (clr[i]) begin
                val_d[i] = '0;
                ovf_d[i] = 1'b0;
                hit_d[i] = 1'b0;
            end else if (en[i]) begin
                val_d[i] = (sat_mode && sum[i][WIDTH_P]) ? '1 : sum[i][WIDTH_P-1:0];
                // A carry overrides a same-cycle acknowledge so no overflow event is lost.
                if (sum[i][WIDTH_P])
                    ovf_d[i] = 1'b1;
                if (sum[i][WIDTH_P] || (val_d[i] >= thr_q))
                    hit_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            thr_q    <= THR_RST;
            overflow <= '0;
            thr_hit  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                val_q[i] <= '0;
        end else begin
            if (thr_we)
                thr_q <= thr_wdata;
            overflow <= ovf_d;
            thr_hit  <= hit_d;
            for (int i = 0; i < NUM_CH; i++)
                val_q[i] <= val_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign val[g*WIDTH_P +: WIDTH_P] = val_q[g];
        assign non_zero[g]               = |val_q[g];
    end

    assign any_ovf = |overflow;

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: vector table, directed corner sequences and random vs. model.
module tb_multi_counter;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic           clk1 = 1'b0;
    logic           reset;
    logic [N-1:0]   en, clr, ovf_ack;
    logic [N*W-1:0] inc;
    logic           sat_mode, thr_we;
    logic [W-1:0]   thr_wdata;
    logic [N*W-1:0] val;
    logic [N-1:0]   overflow, thr_hit, non_zero;
    logic           any_ovf;

    int checks   = 0;
    int failures = 0;

    multi_counter #(.WIDTH_P(W), .NUM_CH(N), .THR_RST(8'd0)) dut (
        .clk1(clk1), .reset(reset), .en(en), .clr(clr), .inc(inc),
        .sat_mode(sat_mode), .thr_we(thr_we), .thr_wdata(thr_wdata),
        .ovf_ack(ovf_ack), .val(val), .overflow(overflow), .thr_hit(thr_hit),
        .non_zero(non_zero), .any_ovf(any_ovf)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<400000", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: per-channel integers, counts computed with plain arithmetic.
    int m_val [N];
    bit m_ovf [N];
    bit m_hit [N];
    int m_thr;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0; m_ovf[i] = 0; m_hit[i] = 0;
        end
        m_thr = 0;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            int s, nv;
            bit c;
            s = m_val[i] + int'(inc[i*W +: W]);
            c = (s > MAXV);
            if (clr[i]) begin
                m_val[i] = 0; m_ovf[i] = 0; m_hit[i] = 0;
            end else begin
                if (ovf_ack[i]) m_ovf[i] = 0;
                if (en[i]) begin
                    nv = c ? (sat_mode ? MAXV : s % (MAXV + 1)) : s;
                    if (c) m_ovf[i] = 1;
                    if (c || nv >= m_thr) m_hit[i] = 1;
                    m_val[i] = nv;
                end
            end
        end
        if (thr_we) m_thr = int'(thr_wdata);
    endfunction

    function automatic logic [N*W-1:0] model_val_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_val[i][W-1:0];
        return v;
    endfunction

    function automatic logic [N-1:0] model_flag_vec(input bit sel_hit);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = sel_hit ? m_hit[i] : m_ovf[i];
        return v;
    endfunction

    function automatic logic [N-1:0] nz_of(input logic [N*W-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (v[i*W +: W] != '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [N*W-1:0] e_val,
                                 input logic [N-1:0] e_ovf, input logic [N-1:0] e_hit);
        check({tag, ".val"},      val,                e_val);
        check({tag, ".overflow"}, {28'd0, overflow},  {28'd0, e_ovf});
        check({tag, ".thr_hit"},  {28'd0, thr_hit},   {28'd0, e_hit});
        check({tag, ".non_zero"}, {28'd0, non_zero},  {28'd0, nz_of(e_val)});
        check({tag, ".any_ovf"},  {31'd0, any_ovf},   {31'd0, |e_ovf});
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, model_val_vec(), model_flag_vec(1'b0), model_flag_vec(1'b1));
    endtask

    task automatic idle_inputs();
        en = '0; clr = '0; ovf_ack = '0; inc = '0;
        sat_mode = 1'b0; thr_we = 1'b0; thr_wdata = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk1);
        #1;
    endtask

    typedef struct {
        logic [N-1:0]   en;
        logic [N-1:0]   clr;
        logic [N*W-1:0] inc;
        logic           sat;
        logic           we;
        logic [W-1:0]   wd;
        logic [N-1:0]   ack;
        logic [N*W-1:0] e_val;
        logic [N-1:0]   e_ovf;
        logic [N-1:0]   e_hit;
    } vec_t;

    vec_t tbl [11];

    initial begin
        //            en       clr      inc           sat   we    wd      ack      e_val         e_ovf    e_hit
        tbl[0]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b1, 8'd200, 4'b0000, 32'h00000000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0110, 4'b0000, 32'h00FAFA00, 1'b0, 1'b0, 8'd0,   4'b0000, 32'h00FAFA00, 4'b0000, 4'b0110};
        tbl[2]  = '{4'b0010, 4'b0000, 32'h00000A00, 1'b0, 1'b0, 8'd0,   4'b0000, 32'h00FA0400, 4'b0010, 4'b0110};
        tbl[3]  = '{4'b0100, 4'b0000, 32'h000A0000, 1'b1, 1'b0, 8'd0,   4'b0010, 32'h00FF0400, 4'b0100, 4'b0110};
        tbl[4]  = '{4'b0100, 4'b0000, 32'h00010000, 1'b1, 1'b0, 8'd0,   4'b0000, 32'h00FF0400, 4'b0100, 4'b0110};
        tbl[5]  = '{4'b0100, 4'b0000, 32'h00010000, 1'b1, 1'b0, 8'd0,   4'b0100, 32'h00FF0400, 4'b0100, 4'b0110};
        tbl[6]  = '{4'b1000, 4'b0000, 32'hFF000000, 1'b0, 1'b0, 8'd0,   4'b0000, 32'hFFFF0400, 4'b0100, 4'b1110};
        tbl[7]  = '{4'b1000, 4'b1000, 32'h07000000, 1'b0, 1'b0, 8'd0,   4'b0000, 32'h00FF0400, 4'b0100, 4'b0110};
        tbl[8]  = '{4'b0001, 4'b0000, 32'h00000000, 1'b0, 1'b0, 8'd0,   4'b0000, 32'h00FF0400, 4'b0100, 4'b0110};
        tbl[9]  = '{4'b0010, 4'b0000, 32'h0000FC00, 1'b1, 1'b0, 8'd0,   4'b0000, 32'h00FFFF00, 4'b0110, 4'b0110};
        tbl[10] = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 8'd0,   4'b0000, 32'h00FFFF00, 4'b0110, 4'b0110};

        idle_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        check_outputs("reset", '0, '0, '0);
        @(negedge clk1);
        reset = 1'b0;

        // Wrap, saturate, ack and clear priorities from a known vector table.
        for (int r = 0; r < 11; r++) begin
            en = tbl[r].en; clr = tbl[r].clr; inc = tbl[r].inc; sat_mode = tbl[r].sat;
            thr_we = tbl[r].we; thr_wdata = tbl[r].wd; ovf_ack = tbl[r].ack;
            tick();
            check_outputs($sformatf("tbl%0d", r), tbl[r].e_val, tbl[r].e_ovf, tbl[r].e_hit);
        end

        // Asynchronous reset between edges while channel 0 counts by 5.
        idle_inputs();
        en = 4'b0001; inc = 32'h00000005;
        repeat (3) tick();
        check("count15", {24'd0, val[7:0]}, 32'd15);
        #3 reset = 1'b1;
        #1;
        check_outputs("async_reset", '0, '0, '0);
        idle_inputs();
        model_reset();
        @(negedge clk1);
        reset = 1'b0;

        // Threshold crossing at 102, not at 96.
        thr_we = 1'b1; thr_wdata = 8'd100; tick();
        idle_inputs(); en = 4'b0001; inc = 32'd90; tick();
        check("thr_at90", {31'd0, thr_hit[0]}, 32'd0);
        inc = 32'd6; tick();
        check("thr_at96", {31'd0, thr_hit[0]}, 32'd0);
        check("val_96", {24'd0, val[7:0]}, 32'd96);
        tick();
        check("thr_at102", {31'd0, thr_hit[0]}, 32'd1);
        check("val_102", {24'd0, val[7:0]}, 32'd102);

        // Same-cycle threshold write: the compare uses the old value.
        idle_inputs(); en = 4'b0010; inc = 32'h00003200; tick();
        inc = 32'h00000A00; thr_we = 1'b1; thr_wdata = 8'd40; tick();
        check("thr_old_low", {31'd0, thr_hit[1]}, 32'd0);
        idle_inputs(); en = 4'b0100; inc = 32'h00780000; thr_we = 1'b1; thr_wdata = 8'd200; tick();
        check("thr_old_high", {31'd0, thr_hit[2]}, 32'd1);
        idle_inputs(); en = 4'b0010; tick();
        check("thr_zero_inc_hit", {31'd0, thr_hit[1]}, 32'd0);
        check_model("thr_seq");

        // Channel independence.
        idle_inputs(); clr = 4'b1111; tick();
        idle_inputs(); en = 4'b1111; inc = 32'h04030201;
        repeat (10) tick();
        check("indep.val", val, 32'h281E140A);
        check("indep.non_zero", {28'd0, non_zero}, 32'h0000000F);
        check("indep.overflow", {28'd0, overflow}, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            int unsigned r0, r1, r2;
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            en        = r0[3:0];
            clr       = ($urandom_range(0, 7) == 0) ? r0[7:4] : 4'b0000;
            ovf_ack   = ($urandom_range(0, 3) == 0) ? r0[11:8] : 4'b0000;
            inc       = r1;
            sat_mode  = r0[12];
            thr_we    = ($urandom_range(0, 9) == 0);
            thr_wdata = r2[7:0];
            tick();
            check_model($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
